bus_resp_fifo: RTL and testbench

Response buffer between the last core on the bus chain and bridge_tx. It captures read responses (valid_i && !rw_i) from the core chain into a FIFO. It then issues them to bridge_tx one at a time, only when bridge_tx is idle. Without it, back-to-back read responses arriving while bridge_tx is serialising are silently lost.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/bus_resp_fifo.sv | 131 +++++++++++++
 tb/tb_bus_resp_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared bus widths, bus transaction type and the issue-FSM
//                state encoding for the response buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    // One bus transaction as seen on the core chain
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data;
        logic                  rw;
    } bus_xact_t;

    // Issue FSM: IDLE waits for a stored response and an idle downstream,
    // WAIT gives the downstream time to report busy after an issue.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } issue_state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Generic synchronous FIFO with extra-bit read/write pointers,
//                head-of-queue read data and a registered occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_ONE   = {{c_PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic [c_PTR_W:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB separates "same slot, same lap" (empty) from
    // "same slot, one lap apart" (full).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    assign dout  = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/bus_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bus_resp_fifo
//  Description : Buffers read responses from the core chain and hands them to
//                bridge_tx one at a time, only while bridge_tx reports idle.
//                Flags responses dropped because the buffer was full.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_resp_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BUS_ADDR_W-1:0]   addr_i,
    input  logic [BUS_DATA_W-1:0]   data_i,
    input  logic                    rw_i,
    input  logic                    valid_i,
    input  logic                    ready_i,
    input  logic                    clear_i,
    output logic [BUS_ADDR_W-1:0]   addr_o,
    output logic [BUS_DATA_W-1:0]   data_o,
    output logic                    rw_o,
    output logic                    valid_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int              c_PTR_W   = $clog2(DEPTH);
    localparam int              c_ENTRY_W = BUS_ADDR_W + BUS_DATA_W;
    localparam int              c_TMR_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    issue_state_t          r_state;
    bus_xact_t             r_issue;
    logic                  r_valid;
    logic                  r_overflow;
    logic [c_TMR_W-1:0]    r_timer;

    logic                  w_is_read;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [c_ENTRY_W-1:0]  w_head;
    logic [c_PTR_W:0]      w_count;

    // Only read responses are buffered; bus writes and idle cycles pass by
    assign w_is_read = valid_i && !rw_i;

    // Issue (and therefore pop) only from IDLE with an idle downstream
    assign w_pop  = (r_state == IDLE) && !w_empty && ready_i;
    assign w_push = w_is_read && (!w_full || w_pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({addr_i, data_i}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Issue FSM: registers the head entry as a one-cycle strobe, then waits
    // for downstream to go busy or for the acknowledge timeout to expire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_issue <= '0;
            r_valid <= 1'b0;
            r_timer <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (w_pop) begin
                        r_issue.addr <= w_head[c_ENTRY_W-1:BUS_DATA_W];
                        r_issue.data <= w_head[BUS_DATA_W-1:0];
                        r_issue.rw   <= 1'b0;
                        r_valid      <= 1'b1;
                        r_timer      <= c_TMR_LOAD;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    r_valid <= 1'b0;
                    if (!ready_i) begin
                        r_state <= IDLE;
                    end else if (r_timer == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer - c_TMR_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flag; a new drop takes priority over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_is_read && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign addr_o     = r_issue.addr;
    assign data_o     = r_issue.data;
    assign rw_o       = r_issue.rw;
    assign valid_o    = r_valid;
    assign count_o    = w_count;
    assign overflow_o = r_overflow;

endmodule : bus_resp_fifo
`default_nettype wire

// File: tb/tb_bus_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_resp_fifo
//  Description : Directed self-checking bench for bus_resp_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_resp_fifo;

    localparam int c_DEPTH = 16;
    localparam int c_ACK   = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr_i;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic        ready_i;
    logic        clear_i;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;
    logic [4:0]  count_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bus_resp_fifo #(
        .DEPTH       (c_DEPTH),
        .ACK_TIMEOUT (c_ACK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .ready_i    (ready_i),
        .clear_i    (clear_i),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .rw_o       (rw_o),
        .valid_o    (valid_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one bus transaction for a single cycle
    task automatic bus_cycle(input logic rw, input logic [15:0] a, input logic [15:0] d);
        valid_i = 1'b1;
        rw_i    = rw;
        addr_i  = a;
        data_i  = d;
        tick();
        valid_i = 1'b0;
        rw_i    = 1'b0;
    endtask

    // Tick until valid_o is seen or the budget runs out
    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int bad;
        int peak;
        int t1;
        int t2;
        logic [15:0] exp_d;

        rst_n   = 1'b0;
        addr_i  = '0;
        data_i  = '0;
        rw_i    = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        clear_i = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        check("rst_valid",    {31'd0, valid_o},    32'd0);
        check("rst_count",    {27'd0, count_o},    32'd0);
        check("rst_overflow", {31'd0, overflow_o}, 32'd0);
        check("rst_addr",     {16'd0, addr_o},     32'd0);
        check("rst_data",     {16'd0, data_o},     32'd0);
        rst_n = 1'b1;
        tick();

        // ---- single response: stored at one edge, issued at the next ----
        ready_i = 1'b1;
        bus_cycle(1'b0, 16'h0002, 16'hBEEF);
        check("single_no_early_valid", {31'd0, valid_o}, 32'd0);
        check("single_count_1",        {27'd0, count_o}, 32'd1);
        tick();
        check("single_valid", {31'd0, valid_o}, 32'd1);
        check("single_addr",  {16'd0, addr_o},  32'h0002);
        check("single_data",  {16'd0, data_o},  32'hBEEF);
        check("single_rw",    {31'd0, rw_o},    32'd0);
        check("single_count_0", {27'd0, count_o}, 32'd0);
        tick();
        check("single_strobe_1cyc", {31'd0, valid_o}, 32'd0);
        for (int k = 0; k < 6; k++) tick();

        // ---- burst while downstream busy, then bridge-like handshake ----
        ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) bus_cycle(1'b0, 16'(i), 16'(i));
        check("burst_count_5", {27'd0, count_o}, 32'd5);
        check("burst_no_valid", {31'd0, valid_o}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            ready_i = 1'b1;
            wait_valid(10, seen);
            check("burst_issue_seen", {31'd0, seen}, 32'd1);
            check("burst_issue_data", {16'd0, data_o}, 32'(i));
            ready_i = 1'b0;
            bad = 0;
            for (int k = 0; k < 70; k++) begin
                tick();
                if (valid_o) bad++;
            end
            check("burst_no_valid_while_busy", 32'(bad), 32'd0);
        end
        check("burst_drained", {27'd0, count_o}, 32'd0);

        // ---- write filter ----
        peak = 0;
        bus_cycle(1'b1, 16'h0010, 16'h1234); if (int'(count_o) > peak) peak = int'(count_o);
        bus_cycle(1'b0, 16'h0011, 16'h00AA); if (int'(count_o) > peak) peak = int'(count_o);
        bus_cycle(1'b1, 16'h0012, 16'h1234); if (int'(count_o) > peak) peak = int'(count_o);
        bus_cycle(1'b1, 16'h0013, 16'h1234); if (int'(count_o) > peak) peak = int'(count_o);
        check("filter_peak", 32'(peak), 32'd1);
        ready_i = 1'b1;
        wait_valid(10, seen);
        check("filter_issue_seen", {31'd0, seen}, 32'd1);
        check("filter_issue_data", {16'd0, data_o}, 32'h00AA);
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid_o) bad++;
        end
        check("filter_only_one_issue", 32'(bad), 32'd0);
        check("filter_count_0", {27'd0, count_o}, 32'd0);

        // ---- overflow ----
        ready_i = 1'b0;
        for (int i = 0; i < 16; i++) bus_cycle(1'b0, 16'(i), 16'(16'h0100 + i));
        check("ovf_full_no_flag", {31'd0, overflow_o}, 32'd0);
        bus_cycle(1'b0, 16'h00F0, 16'h0110);
        bus_cycle(1'b0, 16'h00F1, 16'h0111);
        check("ovf_count_16", {27'd0, count_o},    32'd16);
        check("ovf_flag",     {31'd0, overflow_o}, 32'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_valid(10, seen);
            check("ovf_drain_seen", {31'd0, seen}, 32'd1);
            check("ovf_drain_data", {16'd0, data_o}, 32'(16'h0100 + i));
        end
        for (int k = 0; k < 6; k++) tick();
        check("ovf_drained",     {27'd0, count_o},    32'd0);
        check("ovf_still_sticky", {31'd0, overflow_o}, 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("ovf_cleared", {31'd0, overflow_o}, 32'd0);

        // ---- full with simultaneous pop (and set-wins-over-clear) ----
        ready_i = 1'b0;
        for (int i = 0; i < 16; i++) bus_cycle(1'b0, 16'(i), 16'(16'h0200 + i));
        check("fullpop_count_16", {27'd0, count_o}, 32'd16);
        clear_i = 1'b1;
        bus_cycle(1'b0, 16'h0EEE, 16'hDEAD);
        check("set_wins_over_clear", {31'd0, overflow_o}, 32'd1);
        tick();
        clear_i = 1'b0;
        check("clear_alone", {31'd0, overflow_o}, 32'd0);
        ready_i = 1'b1;
        bus_cycle(1'b0, 16'h02FF, 16'h02FF);
        check("fullpop_valid",    {31'd0, valid_o},    32'd1);
        check("fullpop_data",     {16'd0, data_o},     32'h0200);
        check("fullpop_count",    {27'd0, count_o},    32'd16);
        check("fullpop_no_ovf",   {31'd0, overflow_o}, 32'd0);
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 16'(16'h0201 + i) : 16'h02FF;
            wait_valid(10, seen);
            check("fullpop_drain_seen", {31'd0, seen}, 32'd1);
            check("fullpop_drain_data", {16'd0, data_o}, {16'd0, exp_d});
        end
        for (int k = 0; k < 6; k++) tick();

        // ---- timeout spacing with downstream never going busy ----
        bus_cycle(1'b0, 16'h0301, 16'h0301);
        bus_cycle(1'b0, 16'h0302, 16'h0302);
        check("tmo_first_valid", {31'd0, valid_o}, 32'd1);
        check("tmo_first_data",  {16'd0, data_o},  32'h0301);
        t1 = cyc;
        wait_valid(12, seen);
        t2 = cyc;
        check("tmo_second_seen", {31'd0, seen},   32'd1);
        check("tmo_second_data", {16'd0, data_o}, 32'h0302);
        check("tmo_spacing",     32'(t2 - t1),    32'(c_ACK + 1));
        for (int k = 0; k < 6; k++) tick();

        // ---- reset mid-operation ----
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) bus_cycle(1'b0, 16'(16'h0400 + i), 16'(16'h0400 + i));
        check("rst_mid_count_3", {27'd0, count_o}, 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_count",    {27'd0, count_o},    32'd0);
        check("rst_mid_addr",     {16'd0, addr_o},     32'd0);
        check("rst_mid_data",     {16'd0, data_o},     32'd0);
        check("rst_mid_valid",    {31'd0, valid_o},    32'd0);
        check("rst_mid_overflow", {31'd0, overflow_o}, 32'd0);
        ready_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid_o) bad++;
        end
        check("rst_mid_no_issue", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bus_resp_fifo
`default_nettype wire
